// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the MD5 message padder
package md5_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] block_t;

  typedef enum logic [1:0] {
    S_FILL,
    S_OUT,
    S_LEN,
    S_PADLEN
  } pad_state_e;

  // Follow-on block still owed after the current one is handed over.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_LEN,
    PEND_PADLEN
  } pend_e;

  localparam logic [7:0] PAD_BYTE      = 8'h80;
  localparam word_t      PAD_WORD      = {24'h000000, PAD_BYTE};
  localparam int         LEN_LO_IDX    = 14;
  localparam int         LEN_HI_IDX    = 15;
  localparam int         LAST_DATA_IDX = 13;

endpackage

// File: rtl/md5_pad_word.sv
// rtl/md5_pad_word.sv - keeps lanes below k, puts 0x80 in lane k, zeroes the rest
module md5_pad_word
  import md5_pkg::*;
(
  input  word_t      i_data,
  input  logic [2:0] i_k,
  output word_t      o_word
);

  always_comb begin
    o_word = '0;
    for (int n = 0; n < 4; n++) begin
      if (3'(n) < i_k) begin
        o_word[8*n +: 8] = i_data[8*n +: 8];
      end else if (3'(n) == i_k) begin
        o_word[8*n +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/md5_padder.sv
// rtl/md5_padder.sv - RFC 1321 padder turning a 32-bit word stream into 512-bit MD5 blocks
module md5_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_nbytes_i,
  output logic        in_ready_o,
  output block_t      blk_o,
  output logic        blk_valid_o,
  input  logic        blk_ready_i,
  output logic        blk_first_o,
  output logic        blk_last_o
);

  pad_state_e       r_state;
  pad_state_e       w_next_state;
  pend_e            r_pend;
  block_t           r_buf;
  logic [3:0]       r_idx;
  logic [LEN_W-1:0] r_cnt;
  logic             r_first;
  logic             r_last;
  logic             r_run;

  logic             w_accept;
  logic             w_out_hs;
  logic [2:0]       w_k;
  logic [2:0]       w_add;
  logic [4:0]       w_p;
  logic [LEN_W-1:0] w_cnt_next;
  logic [63:0]      w_len_next;
  logic [63:0]      w_len_cur;
  word_t            w_pad_word;

  function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] bytes);
    return 64'({bytes, 3'b000});
  endfunction

  assign w_accept   = in_valid_i & in_ready_o;
  assign w_out_hs   = blk_valid_o & blk_ready_i;
  assign w_k        = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
  assign w_add      = in_last_i ? w_k : 3'd4;
  assign w_cnt_next = r_cnt + LEN_W'(w_add);
  // p is the word that receives the 0x80 byte; a full last word pushes it one word on.
  assign w_p        = {1'b0, r_idx} + {4'd0, (w_k == 3'd4)};
  assign w_len_next = bit_len(w_cnt_next);
  assign w_len_cur  = bit_len(r_cnt);

  md5_pad_word u_pad_word (
    .i_data (in_data_i),
    .i_k    (w_k),
    .o_word (w_pad_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && (in_last_i || (r_idx == 4'd15))) begin
          w_next_state = S_OUT;
        end
      end
      S_OUT: begin
        if (w_out_hs) begin
          case (r_pend)
            PEND_LEN:    w_next_state = S_LEN;
            PEND_PADLEN: w_next_state = S_PADLEN;
            default:     w_next_state = S_FILL;
          endcase
        end
      end
      S_LEN:    w_next_state = S_OUT;
      S_PADLEN: w_next_state = S_OUT;
      default:  w_next_state = S_FILL;
    endcase
  end

  // r_run keeps the input closed for the first cycle after reset is released.
  always_comb begin
    in_ready_o  = r_run && (r_state == S_FILL);
    blk_valid_o = (r_state == S_OUT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_last  <= 1'b0;
      r_pend  <= PEND_NONE;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_idx <= r_idx + 4'd1;
            r_cnt <= w_cnt_next;
            if (!in_last_i) begin
              r_buf[r_idx] <= in_data_i;
              r_last       <= 1'b0;
            end else begin
              r_buf[r_idx] <= w_pad_word;
              if ((w_k == 3'd4) && (r_idx != 4'd15)) begin
                r_buf[r_idx + 4'd1] <= PAD_WORD;
              end
              if (w_p <= 5'(LAST_DATA_IDX)) begin
                r_buf[LEN_LO_IDX] <= w_len_next[31:0];
                r_buf[LEN_HI_IDX] <= w_len_next[63:32];
                r_last            <= 1'b1;
              end else begin
                r_last <= 1'b0;
                r_pend <= (w_p == 5'd16) ? PEND_PADLEN : PEND_LEN;
              end
            end
          end
        end
        S_OUT: begin
          if (w_out_hs) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_first <= r_last;
            r_last  <= 1'b0;
            r_pend  <= PEND_NONE;
            if (r_last) begin
              r_cnt <= '0;
            end
          end
        end
        S_LEN: begin
          r_buf[LEN_LO_IDX] <= w_len_cur[31:0];
          r_buf[LEN_HI_IDX] <= w_len_cur[63:32];
          r_last            <= 1'b1;
        end
        S_PADLEN: begin
          r_buf[0]          <= PAD_WORD;
          r_buf[LEN_LO_IDX] <= w_len_cur[31:0];
          r_buf[LEN_HI_IDX] <= w_len_cur[63:32];
          r_last            <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign blk_o       = r_buf;
  assign blk_first_o = r_first;
  assign blk_last_o  = r_last;

endmodule

// File: tb/tb_md5_padder.sv
// tb/tb_md5_padder.sv - randomized self-checking bench for md5_padder
module tb_md5_padder;
  import md5_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_last_i;
  logic [2:0]  in_nbytes_i;
  logic        in_ready_o;
  block_t      blk_o;
  logic        blk_valid_o;
  logic        blk_ready_i;
  logic        blk_first_o;
  logic        blk_last_o;

  always #5 clk_i = ~clk_i;

  md5_padder #(.LEN_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_nbytes_i (in_nbytes_i),
    .in_ready_o  (in_ready_o),
    .blk_o       (blk_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_first_o (blk_first_o),
    .blk_last_o  (blk_last_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [2:0]  nb;
  } tx_word_t;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [15:0][31:0] w;
  } exp_blk_t;

  tx_word_t tx_q[$];
  exp_blk_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int msg_id  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: RFC 1321 padding on a byte array, cut into 64-byte little-endian blocks.
  function automatic int model_blocks(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] bl;
    exp_blk_t    e;
    int          nblk;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      for (int j = 0; j < 16; j++)
        e.w[j] = {p[64*b+4*j+3], p[64*b+4*j+2], p[64*b+4*j+1], p[64*b+4*j]};
      exp_q.push_back(e);
    end
    return nblk;
  endfunction

  // mode 0: random framing, 1: full last word with nbytes=4, 2: separate terminator word
  function automatic void frame(input logic [7:0] m[$], input int mode);
    tx_word_t w;
    int L, nfull, rem;
    bit term;
    L     = m.size();
    nfull = L / 4;
    rem   = L % 4;
    term  = (mode == 2) || ((mode == 0) && ($urandom_range(0, 1) == 1)) || (L == 0);
    tx_q.delete();
    for (int i = 0; i < nfull; i++) begin
      w.d    = {m[4*i+3], m[4*i+2], m[4*i+1], m[4*i]};
      w.last = (rem == 0) && !term && (i == nfull - 1);
      if (w.last) w.nb = ((mode == 0) && ($urandom_range(0, 2) == 0)) ? 3'($urandom_range(5, 7)) : 3'd4;
      else        w.nb = 3'($urandom);
      tx_q.push_back(w);
    end
    if (rem > 0) begin
      w.d = $urandom;
      for (int b = 0; b < rem; b++) w.d[8*b +: 8] = m[4*nfull+b];
      w.last = 1'b1;
      w.nb   = 3'(rem);
      tx_q.push_back(w);
    end else if (term) begin
      w.d    = $urandom;
      w.last = 1'b1;
      w.nb   = 3'd0;
      tx_q.push_back(w);
    end
  endfunction

  task automatic wait_ready(output bit ok, input int budget);
    int t;
    t = 0;
    while (!in_ready_o && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    ok = in_ready_o;
  endtask

  task automatic send_words();
    bit ok;
    bit chk_lat;
    chk_lat = 1'b0;
    foreach (tx_q[i]) begin
      @(negedge clk_i);
      if (chk_lat) check($sformatf("m%0d_latency_w%0d", msg_id, i - 1), blk_valid_o, 1);
      chk_lat = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        @(negedge clk_i);
      end
      in_data_i   = tx_q[i].d;
      in_last_i   = tx_q[i].last;
      in_nbytes_i = tx_q[i].nb;
      in_valid_i  = 1'b1;
      wait_ready(ok, 1000);
      if (!ok) begin
        check($sformatf("m%0d_tx_timeout", msg_id), 0, 1);
        in_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      chk_lat = tx_q[i].last || ((i % 16) == 15);
    end
    @(negedge clk_i);
    if (chk_lat) check($sformatf("m%0d_latency_end", msg_id), blk_valid_o, 1);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic recv_blocks(input int n);
    exp_blk_t e;
    int got, t;
    got = 0;
    t   = 0;
    while (got < n && t < 4000) begin
      @(negedge clk_i);
      t++;
      blk_ready_i = ($urandom_range(0, 3) != 0);
      if (blk_valid_o && blk_ready_i) begin
        e = exp_q.pop_front();
        for (int j = 0; j < 16; j++)
          check($sformatf("m%0d_b%0d_w%0d", msg_id, got, j), 64'(blk_o[j]), 64'(e.w[j]));
        check($sformatf("m%0d_b%0d_first", msg_id, got), blk_first_o, e.first);
        check($sformatf("m%0d_b%0d_last", msg_id, got), blk_last_o, e.last);
        got++;
      end
    end
    if (got < n) begin
      check($sformatf("m%0d_rx_timeout", msg_id), got, n);
      exp_q.delete();
    end
    @(negedge clk_i);
    blk_ready_i = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] m[$], input int mode);
    int n;
    n = model_blocks(m);
    frame(m, mode);
    fork
      send_words();
      recv_blocks(n);
    join
    msg_id++;
  endtask

  logic [7:0] msg[$];
  block_t     snap;
  bit         ok;
  int         bounds[11] = '{0, 3, 52, 55, 56, 57, 60, 63, 64, 119, 120};
  int         len;

  initial begin
    rst_i       = 1'b1;
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    in_nbytes_i = '0;
    blk_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", blk_valid_o, 0);
    check("rst_ready", in_ready_o, 0);
    check("rst_first", blk_first_o, 1);
    check("rst_last", blk_last_o, 0);
    check("rst_blk_zero", 64'(blk_o != '0), 0);
    rst_i = 1'b0;
    check("rel_ready0", in_ready_o, 0);
    @(negedge clk_i);
    check("rel_ready1", in_ready_o, 1);

    msg.delete();
    run_msg(msg, 2);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 0);
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1);
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1);

    // Output backpressure with the next message's word held at the input.
    @(negedge clk_i);
    in_data_i   = 32'hAB636261;
    in_last_i   = 1'b1;
    in_nbytes_i = 3'd3;
    in_valid_i  = 1'b1;
    wait_ready(ok, 20);
    check("bp_tx_ready", ok, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    check("bp_latency", blk_valid_o, 1);
    in_data_i   = $urandom;
    in_nbytes_i = 3'd0;
    snap = blk_o;
    check("bp_w0", blk_o[0], 32'h80636261);
    check("bp_w1", blk_o[1], 0);
    check("bp_w14", blk_o[14], 32'h00000018);
    check("bp_w15", blk_o[15], 0);
    check("bp_first", blk_first_o, 1);
    check("bp_last", blk_last_o, 1);
    repeat (10) begin
      @(negedge clk_i);
      check("bp_hold_ready", in_ready_o, 0);
      check("bp_hold_valid", blk_valid_o, 1);
      check("bp_hold_blk", 64'(blk_o == snap), 1);
      check("bp_hold_first", blk_first_o, 1);
      check("bp_hold_last", blk_last_o, 1);
    end
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    blk_ready_i = 1'b0;
    check("bp_hs_valid", blk_valid_o, 0);
    wait_ready(ok, 4);
    check("bp_ready_back", ok, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    check("bp_term_valid", blk_valid_o, 1);
    check("bp_term_w0", blk_o[0], 32'h00000080);
    check("bp_term_w14", blk_o[14], 0);
    check("bp_term_first", blk_first_o, 1);
    check("bp_term_last", blk_last_o, 1);
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    blk_ready_i = 1'b0;

    // Asynchronous reset part-way through a block.
    tx_q.delete();
    for (int i = 0; i < 7; i++) tx_q.push_back(tx_word_t'{d: $urandom, last: 1'b0, nb: 3'($urandom)});
    send_words();
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_valid", blk_valid_o, 0);
    check("mid_rst_ready", in_ready_o, 0);
    check("mid_rst_first", blk_first_o, 1);
    check("mid_rst_last", blk_last_o, 0);
    check("mid_rst_blk_zero", 64'(blk_o != '0), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rel_ready0", in_ready_o, 0);
    @(negedge clk_i);
    check("mid_rel_ready1", in_ready_o, 1);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 0);

    for (int r = 0; r < 40; r++) begin
      len = ($urandom_range(0, 2) == 0) ? bounds[$urandom_range(0, 10)] : int'($urandom_range(0, 150));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg(msg, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
